// File: rtl/melody_sequencer.sv
// melody_sequencer - plays {duration, period} notes from a writable table, one beat strobe at a time.
module melody_sequencer #(
  parameter int PERIOD_W = 20,
  parameter int DUR_W    = 3,
  parameter int ADDR_W   = 6
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      beat,
  input  logic                      wr_en,
  input  logic [ADDR_W-1:0]         wr_addr,
  input  logic [DUR_W+PERIOD_W-1:0] wr_data,
  input  logic                      play,
  input  logic                      stop,
  input  logic                      loop,
  input  logic [ADDR_W-1:0]         last_step,
  output logic [PERIOD_W-1:0]       sound,
  output logic [ADDR_W-1:0]         step,
  output logic                      playing,
  output logic                      done
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int W     = DUR_W + PERIOD_W;

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state;
  logic [W-1:0]      mem [DEPTH];
  logic [W-1:0]      rd_data;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] last_q;
  logic [DUR_W-1:0]  cnt;

  // Address the step that the next FETCH will hold, so rd_data is valid during FETCH.
  always_comb begin
    fetch_addr = '0;
    if (state == HOLD && step != last_q) fetch_addr = step + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    rd_data <= mem[fetch_addr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sound   <= '0;
      step    <= '0;
      playing <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      last_q  <= '0;
    end else begin
      done <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        sound   <= '0;
        step    <= '0;
        playing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            sound <= '0;
            if (play) begin
              last_q  <= last_step;
              step    <= '0;
              state   <= FETCH;
              playing <= 1'b1;
            end
          end
          FETCH: begin
            sound <= rd_data[PERIOD_W-1:0];
            cnt   <= rd_data[W-1 -: DUR_W];
            state <= HOLD;
          end
          HOLD: begin
            if (beat) begin
              if (cnt != '0) begin
                cnt <= cnt - DUR_W'(1);
              end else if (step != last_q) begin
                step  <= step + ADDR_W'(1);
                state <= FETCH;
              end else if (loop) begin
                step  <= '0;
                state <= FETCH;
              end else begin
                state   <= IDLE;
                sound   <= '0;
                step    <= '0;
                playing <= 1'b0;
                done    <= 1'b1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_melody_sequencer.sv
// tb_melody_sequencer - directed stimulus against a note-level model of the sequencer.
module tb_melody_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        beat = 1'b0;
  logic        wr_en = 1'b0;
  logic [5:0]  wr_addr = '0;
  logic [22:0] wr_data = '0;
  logic        play = 1'b0;
  logic        stop = 1'b0;
  logic        loop = 1'b0;
  logic [5:0]  last_step = '0;
  logic [19:0] sound;
  logic [5:0]  step;
  logic        playing;
  logic        done;

  int checks = 0;
  int failures = 0;

  melody_sequencer dut (
    .clk(clk), .rst(rst), .beat(beat), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .play(play), .stop(stop), .loop(loop), .last_step(last_step),
    .sound(sound), .step(step), .playing(playing), .done(done)
  );

  always #5 clk = ~clk;

  // Note-level model: a playback is either idle, in its fetch gap, or sounding a
  // note with some number of beats remaining.
  logic [22:0] tbl [64];
  bit          m_active, m_gap, m_done;
  int          m_beats, m_step, m_last, m_sound;
  logic [22:0] m_fetched;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active = 0; m_gap = 0; m_done = 0;
      m_beats = 0; m_step = 0; m_last = 0; m_sound = 0;
    end else begin
      m_done = 0;
      if (stop) begin
        m_active = 0; m_gap = 0; m_step = 0; m_sound = 0;
      end else if (!m_active) begin
        m_sound = 0;
        if (play) begin
          m_active = 1; m_gap = 1; m_last = last_step; m_step = 0; m_fetched = tbl[0];
        end
      end else if (m_gap) begin
        m_gap = 0;
        m_sound = m_fetched[19:0];
        m_beats = m_fetched[22:20] + 1;
      end else if (beat) begin
        m_beats = m_beats - 1;
        if (m_beats == 0) begin
          if (m_step != m_last) begin
            m_step = (m_step + 1) % 64; m_gap = 1; m_fetched = tbl[m_step];
          end else if (loop) begin
            m_step = 0; m_gap = 1; m_fetched = tbl[0];
          end else begin
            m_active = 0; m_sound = 0; m_step = 0; m_done = 1;
          end
        end
      end
      if (wr_en) tbl[wr_addr] = wr_data;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      checks++;
      if (sound !== 20'(m_sound) || step !== 6'(m_step) ||
          playing !== m_active || done !== m_done) begin
        failures++;
        $display("FAIL model t=%0t sound=%0d/%0d step=%0d/%0d playing=%0b/%0b done=%0b/%0b (actual/required)",
                 $time, sound, m_sound, step, m_step, playing, m_active, done, m_done);
      end
    end
  end

  task automatic lit(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int a, input int d, input int p);
    wr_en = 1'b1; wr_addr = 6'(a); wr_data = {3'(d), 20'(p)};
    cyc();
    wr_en = 1'b0;
  endtask

  task automatic pulse_play();
    play = 1'b1; cyc(); play = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1; cyc(); beat = 1'b0;
  endtask

  task automatic t1_seq(input string tag);
    last_step = 6'd2; loop = 1'b0;
    pulse_play(); cyc();
    lit({tag, "_n0_sound"}, int'(sound), 30303);
    pulse_beat(); cyc();
    lit({tag, "_n1_sound"}, int'(sound), 40486);
    lit({tag, "_n1_step"}, int'(step), 1);
    pulse_beat(); cyc();
    lit({tag, "_n1_beat2"}, int'(sound), 40486);
    pulse_beat(); cyc();
    lit({tag, "_rest"}, int'(sound), 0);
    lit({tag, "_rest_step"}, int'(step), 2);
    pulse_beat();
    lit({tag, "_done"}, int'(done), 1);
    lit({tag, "_idle"}, int'(playing), 0);
    cyc();
    lit({tag, "_done_1clk"}, int'(done), 0);
  endtask

  initial begin
    cyc(2);
    lit("reset_sound", int'(sound), 0);
    lit("reset_playing", int'(playing), 0);
    rst = 1'b0;
    cyc();

    // T1 one-shot
    wr(0, 0, 30303); wr(1, 1, 40486); wr(2, 0, 0);
    t1_seq("t1");

    // T2 loop, three laps
    loop = 1'b1;
    pulse_play(); cyc();
    repeat (12) begin pulse_beat(); cyc(); end
    lit("t2_wrap_step", int'(step), 0);
    lit("t2_wrap_sound", int'(sound), 30303);
    lit("t2_still_playing", int'(playing), 1);
    stop = 1'b1; cyc(); stop = 1'b0;

    // T3 stop together with beat during step 1
    loop = 1'b0;
    pulse_play(); cyc(); pulse_beat(); cyc();
    lit("t3_pre_sound", int'(sound), 40486);
    beat = 1'b1; stop = 1'b1; cyc(); beat = 1'b0; stop = 1'b0;
    lit("t3_sound", int'(sound), 0);
    lit("t3_playing", int'(playing), 0);
    lit("t3_done", int'(done), 0);

    // T4 asynchronous reset mid-note
    pulse_play(); cyc(); pulse_beat(); cyc();
    #2 rst = 1'b1; #1;
    lit("t4_async_sound", int'(sound), 0);
    lit("t4_async_step", int'(step), 0);
    lit("t4_async_playing", int'(playing), 0);
    cyc(); rst = 1'b0; cyc();
    t1_seq("t4");

    // T5 control collisions
    play = 1'b1; stop = 1'b1; cyc(); play = 1'b0; stop = 1'b0;
    lit("t5_play_stop", int'(playing), 0);
    pulse_play(); cyc();
    pulse_play();
    lit("t5_replay_step", int'(step), 0);
    lit("t5_replay_sound", int'(sound), 30303);
    wr(1, 0, 22727);
    pulse_beat(); cyc();
    lit("t5_new_data", int'(sound), 22727);
    pulse_beat(); cyc();
    lit("t5_one_beat", int'(step), 2);
    pulse_beat(); cyc();

    // T6 full depth with wrap
    for (int i = 0; i < 64; i++) wr(i, 0, 1000 + i);
    last_step = 6'd63; loop = 1'b1;
    pulse_play(); cyc();
    repeat (63) begin pulse_beat(); cyc(); end
    lit("t6_last_step", int'(step), 63);
    lit("t6_last_sound", int'(sound), 1063);
    pulse_beat(); cyc();
    lit("t6_wrap_step", int'(step), 0);
    lit("t6_wrap_sound", int'(sound), 1000);
    stop = 1'b1; cyc(); stop = 1'b0; cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
